// File: rtl/pipelined_csel_adder.sv
// Purpose: carry-select adder/subtractor pipelined one carry-select block per stage (NBLK = WIDTH/BLOCK stages).
// Latency: NBLK cycles from input transfer to out_valid; sustains one result per cycle.
// Backpressure: in_ready = !out_valid || out_ready; when low the whole pipeline (valid bits included) holds.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready  operand handshake for a, b, cin, sub (sub=1 gives a-b; cin ignored)
//   out_valid / out_ready result handshake for o, cout (carry out of MSB; 1 = no borrow on sub), ovf (signed overflow)
module pipelined_csel_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || NBLK < 2) begin : g_bad_params
        $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK with at least two blocks");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipeline moves as one; a stall freezes every stage.
    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    // Subtraction folds into addition: a + ~b + 1.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        logic [BLOCK-1:0]         blk_a;
        logic [BLOCK-1:0]         blk_b;
        logic                     blk_c;
        logic                     vld_in;
        logic [BLOCK:0]           s0;
        logic [BLOCK:0]           s1;
        logic [BLOCK:0]           sel;
        logic [(k+1)*BLOCK-1:0]   sum_d;
        logic [(k+1)*BLOCK-1:0]   sum_q;
        logic                     cy_q;
        logic                     vld_q;

        // Stage 0 consumes the live inputs; later stages consume the operand
        // bits carried forward by the previous stage, lowest block first.
        if (k == 0) begin : g_in
            assign blk_a  = a[BLOCK-1:0];
            assign blk_b  = b_eff[BLOCK-1:0];
            assign blk_c  = c0;
            assign vld_in = in_valid;
            assign sum_d  = sel[BLOCK-1:0];
        end else begin : g_in
            assign blk_a  = g_stg[k-1].g_rem.rem_a[BLOCK-1:0];
            assign blk_b  = g_stg[k-1].g_rem.rem_b[BLOCK-1:0];
            assign blk_c  = g_stg[k-1].cy_q;
            assign vld_in = g_stg[k-1].vld_q;
            assign sum_d  = {sel[BLOCK-1:0], g_stg[k-1].sum_q};
        end

        // Both carry hypotheses are formed in parallel; the incoming carry picks one.
        assign s0  = {1'b0, blk_a} + {1'b0, blk_b};
        assign s1  = {1'b0, blk_a} + {1'b0, blk_b} + {{BLOCK{1'b0}}, 1'b1};
        assign sel = blk_c ? s1 : s0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                cy_q  <= sel[BLOCK];
                sum_q <= sum_d;
            end
        end

        // Unresolved operand bits travel alongside, shrinking by one block per stage.
        if (k < NBLK - 1) begin : g_rem
            localparam int RW = (NBLK - 1 - k) * BLOCK;
            logic [RW-1:0] src_a;
            logic [RW-1:0] src_b;
            logic [RW-1:0] rem_a;
            logic [RW-1:0] rem_b;

            if (k == 0) begin : g_src
                assign src_a = a[WIDTH-1:BLOCK];
                assign src_b = b_eff[WIDTH-1:BLOCK];
            end else begin : g_src
                assign src_a = g_stg[k-1].g_rem.rem_a[RW+BLOCK-1:BLOCK];
                assign src_b = g_stg[k-1].g_rem.rem_b[RW+BLOCK-1:BLOCK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a <= '0;
                    rem_b <= '0;
                end else if (adv) begin
                    rem_a <= src_a;
                    rem_b <= src_b;
                end
            end
        end

        // Last block: carry into the MSB is recovered from the MSB sum bit.
        if (k == NBLK - 1) begin : g_ovf
            logic msb_cin;
            logic ovf_q;

            assign msb_cin = sel[BLOCK-1] ^ blk_a[BLOCK-1] ^ blk_b[BLOCK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= msb_cin ^ sel[BLOCK];
                end
            end
        end
    end

    assign out_valid = g_stg[NBLK-1].vld_q;
    assign o         = g_stg[NBLK-1].sum_q;
    assign cout      = g_stg[NBLK-1].cy_q;
    assign ovf       = g_stg[NBLK-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: a 16/4 instance for directed cases and a
// 32/8 instance for randomized traffic, each with its own scoreboard queue
// filled on input transfers and drained by an independent output monitor.
module tb_pipelined_csel_adder;

    typedef struct packed {
        logic [31:0] o;
        logic        c;
        logic        v;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        v16, ir16, ov16, ordy16, cin16, sub16, co16, of16;
    logic [15:0] a16, b16, o16;
    logic        v32, ir32, ov32, ordy32, cin32, sub32, co32, of32;
    logic [31:0] a32, b32, o32;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t q16[$];
    exp_t q32[$];
    int   oc16[$];
    logic        held16 = 1'b0;
    logic [17:0] ho16;
    logic        held32 = 1'b0;
    logic [33:0] ho32;

    pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(ordy16), .o(o16), .cout(co16), .ovf(of16)
    );

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32), .out_ready(ordy32), .o(o32), .cout(co32), .ovf(of32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide addition plus the sign rule for overflow.
    function automatic exp_t model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                   input logic c, input logic s);
        exp_t        r;
        logic [31:0] mask;
        logic [31:0] bo;
        logic [32:0] full;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        bo     = (s ? ~bb : bb) & mask;
        full   = {1'b0, aa & mask} + {1'b0, bo} + {32'h0, (s ? 1'b1 : c)};
        r.o    = full[31:0] & mask;
        r.c    = full[w];
        r.v    = (aa[w-1] == bo[w-1]) && (full[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send16(input logic [15:0] aa, input logic [15:0] bb, input logic c, input logic s);
        int  n    = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            v16 = 1'b1; a16 = aa; b16 = bb; cin16 = c; sub16 = s;
            #1;
            if (ir16) begin
                q16.push_back(model(16, {16'h0, aa}, {16'h0, bb}, c, s));
                done = 1;
            end else if (++n > 50) begin
                chk("send16_timeout", 64'(n), 64'd0);
                done = 1;
            end
        end
        @(posedge clk);
        #1 v16 = 1'b0;
    endtask

    task automatic lat16(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            #2;
            lat++;
        end while (!ov16 && lat < 20);
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain16", 64'(q16.size()), 64'd0);
    endtask

    // Output monitors: pop on every output transfer, and check held results stay put.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (ov16 && held16) chk("hold16", {co16, of16, o16}, ho16);
            if (ov16 && ordy16) begin
                oc16.push_back(cyc);
                held16 = 1'b0;
                if (q16.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL res16_unexpected: got %0h expected none", {co16, of16, o16});
                end else begin
                    e = q16.pop_front();
                    chk("res16", {co16, of16, o16}, {e.c, e.v, e.o[15:0]});
                end
            end else if (ov16) begin
                held16 = 1'b1;
                ho16   = {co16, of16, o16};
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (ov32 && held32) chk("hold32", {co32, of32, o32}, ho32);
            if (ov32 && ordy32) begin
                held32 = 1'b0;
                if (q32.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL res32_unexpected: got %0h expected none", {co32, of32, o32});
                end else begin
                    e = q32.pop_front();
                    chk("res32", {co32, of32, o32}, {e.c, e.v, e.o});
                end
            end else if (ov32) begin
                held32 = 1'b1;
                ho32   = {co32, of32, o32};
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sent;
        int cycles;
        int n;
        rst_n = 1'b0;
        v16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; ordy16 = 1;
        v32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; ordy32 = 1;

        // Reset state
        #12;
        chk("rst_out_valid16", ov16, 0);
        chk("rst_in_ready16", ir16, 1);
        chk("rst_outs16", {co16, of16, o16}, 0);
        chk("rst_out_valid32", ov32, 0);
        chk("rst_in_ready32", ir32, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry out of all-ones, and exact fill latency
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        lat16(lat);
        chk("latency_fill", 64'(lat), 64'd4);
        send16(16'h0005, 16'h0007, 1'b0, 1'b1);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send16(16'h8000, 16'h0001, 1'b1, 1'b1);
        send16(16'h1234, 16'h4321, 1'b1, 1'b0);
        send16(16'h0000, 16'h0000, 1'b1, 1'b1);
        drain16();

        // Eight back-to-back transfers emerge on consecutive cycles
        oc16.delete();
        for (int i = 0; i < 8; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        drain16();
        chk("b2b_count", 64'(oc16.size()), 64'd8);
        if (oc16.size() == 8) chk("b2b_spacing", 64'(oc16[7] - oc16[0]), 64'd7);

        // Output stall: pipeline fills, in_ready drops, then everything drains in order
        oc16.delete();
        @(negedge clk);
        ordy16 = 1'b0;
        fork
            for (int i = 0; i < 5; i++)
                send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            begin
                repeat (8) @(negedge clk);
                #2;
                chk("stall_in_ready", ir16, 0);
                chk("stall_out_valid", ov16, 1);
                @(negedge clk);
                ordy16 = 1'b1;
            end
        join
        drain16();
        chk("stall_count", 64'(oc16.size()), 64'd5);

        // Reset with results in flight
        @(negedge clk);
        ordy16 = 1'b0;
        for (int i = 0; i < 4; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        #2;
        chk("pre_reset_valid", ov16, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", ov16, 0);
        chk("async_reset_outs", {co16, of16, o16}, 0);
        chk("async_reset_in_ready", ir16, 1);
        q16.delete();
        held16 = 1'b0;
        #1;
        rst_n  = 1'b1;
        ordy16 = 1'b1;
        oc16.delete();
        repeat (8) @(negedge clk);
        chk("no_stale", 64'(oc16.size()), 64'd0);
        send16(16'h0003, 16'h0004, 1'b1, 1'b0);
        lat16(lat);
        chk("latency_after_reset", 64'(lat), 64'd4);
        drain16();

        // Randomized traffic with random in_valid/out_ready on the 32-bit instance
        sent = 0;
        cycles = 0;
        while (sent < 10000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            v32    = ($urandom_range(3) != 0);
            a32    = $urandom;
            b32    = $urandom;
            cin32  = 1'($urandom_range(1));
            sub32  = 1'($urandom_range(1));
            ordy32 = ($urandom_range(3) != 0);
            #1;
            if (v32 && ir32) begin
                q32.push_back(model(32, a32, b32, cin32, sub32));
                sent++;
            end
        end
        chk("rand_sent", 64'(sent), 64'd10000);
        @(negedge clk);
        v32    = 1'b0;
        ordy32 = 1'b1;
        n = 0;
        while (q32.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain32", 64'(q32.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
